// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - decode-to-execute pipeline register with stall, flush and bubble counter
module id_ex_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  valid_d,
    input  logic                  regwrite_d,
    input  logic                  memwrite_d,
    input  logic                  jump_d,
    input  logic                  branch_d,
    input  logic                  alu_src_d,
    input  logic [1:0]            result_src_d,
    input  logic [3:0]            alu_control_d,
    input  logic [2:0]            branch_control_d,
    input  logic [XLEN-1:0]       rd1_d,
    input  logic [XLEN-1:0]       rd2_d,
    input  logic [XLEN-1:0]       pc_d,
    input  logic [XLEN-1:0]       pc_plus4_d,
    input  logic [XLEN-1:0]       imm_ext_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    output logic                  valid_e,
    output logic                  regwrite_e,
    output logic                  memwrite_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic                  alu_src_e,
    output logic [1:0]            result_src_e,
    output logic [3:0]            alu_control_e,
    output logic [2:0]            branch_control_e,
    output logic [XLEN-1:0]       rd1_e,
    output logic [XLEN-1:0]       rd2_e,
    output logic [XLEN-1:0]       pc_e,
    output logic [XLEN-1:0]       pc_plus4_e,
    output logic [XLEN-1:0]       imm_ext_e,
    output logic [REG_ADDR_W-1:0] rs1_e,
    output logic [REG_ADDR_W-1:0] rs2_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic capture;
    logic bubble_inc;
    logic cnt_full;

    // A bubble is either an explicit flush or a capture of an empty decode slot.
    assign capture    = !flush_e && !stall_e;
    assign bubble_inc = flush_e || (capture && !valid_d);
    assign cnt_full   = (bubble_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e          <= 1'b0;
            regwrite_e       <= 1'b0;
            memwrite_e       <= 1'b0;
            jump_e           <= 1'b0;
            branch_e         <= 1'b0;
            alu_src_e        <= 1'b0;
            result_src_e     <= '0;
            alu_control_e    <= '0;
            branch_control_e <= '0;
            rd1_e            <= '0;
            rd2_e            <= '0;
            pc_e             <= '0;
            pc_plus4_e       <= '0;
            imm_ext_e        <= '0;
            rs1_e            <= '0;
            rs2_e            <= '0;
            rd_e             <= '0;
        end else if (flush_e) begin
            valid_e          <= 1'b0;
            regwrite_e       <= 1'b0;
            memwrite_e       <= 1'b0;
            jump_e           <= 1'b0;
            branch_e         <= 1'b0;
            alu_src_e        <= 1'b0;
            result_src_e     <= '0;
            alu_control_e    <= '0;
            branch_control_e <= '0;
            rd1_e            <= '0;
            rd2_e            <= '0;
            pc_e             <= '0;
            pc_plus4_e       <= '0;
            imm_ext_e        <= '0;
            rs1_e            <= '0;
            rs2_e            <= '0;
            rd_e             <= '0;
        end else if (!stall_e) begin
            // Invalid slots keep their data but lose all side-effecting control.
            valid_e          <= valid_d;
            regwrite_e       <= valid_d && regwrite_d;
            memwrite_e       <= valid_d && memwrite_d;
            jump_e           <= valid_d && jump_d;
            branch_e         <= valid_d && branch_d;
            alu_src_e        <= valid_d && alu_src_d;
            result_src_e     <= valid_d ? result_src_d : 2'b00;
            alu_control_e    <= valid_d ? alu_control_d : 4'b0000;
            branch_control_e <= valid_d ? branch_control_d : 3'b000;
            rd1_e            <= rd1_d;
            rd2_e            <= rd2_d;
            pc_e             <= pc_d;
            pc_plus4_e       <= pc_plus4_d;
            imm_ext_e        <= imm_ext_d;
            rs1_e            <= rs1_d;
            rs2_e            <= rs2_d;
            rd_e             <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (bubble_inc && !cnt_full) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - table-driven self-checking bench for id_ex_reg
module tb_id_ex_reg;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall_e, flush_e, valid_d;
    logic            regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d;
    logic [1:0]      result_src_d;
    logic [3:0]      alu_control_d;
    logic [2:0]      branch_control_d;
    logic [XLEN-1:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
    logic [RAW-1:0]  rs1_d, rs2_d, rd_d;
    logic            valid_e;
    logic            regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e;
    logic [1:0]      result_src_e;
    logic [3:0]      alu_control_e;
    logic [2:0]      branch_control_e;
    logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
    logic [RAW-1:0]  rs1_e, rs2_e, rd_e;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .jump_d(jump_d), .branch_d(branch_d),
        .alu_src_d(alu_src_d), .result_src_d(result_src_d), .alu_control_d(alu_control_d),
        .branch_control_d(branch_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e),
        .branch_e(branch_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
        .alu_control_e(alu_control_e), .branch_control_e(branch_control_e), .rd1_e(rd1_e),
        .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .bubble_cnt(bubble_cnt)
    );

    // ctrl packing: {regwrite, memwrite, jump, branch, alu_src, result_src[1:0], alu_control[3:0], branch_control[2:0]}
    localparam logic [13:0] C_LOAD   = 14'h2280;
    localparam logic [13:0] C_STORE  = 14'h1200;
    localparam logic [13:0] C_BRANCH = 14'h0409;
    localparam logic [13:0] C_JAL    = 14'h2900;
    localparam logic [13:0] C_RWMW   = 14'h3000;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [13:0] ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        exp_valid;
        logic [13:0] exp_ctrl;
        logic [31:0] exp_pc;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rd;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic st, logic fl, logic v, logic [13:0] c, logic [31:0] p,
                                logic [31:0] i, logic [4:0] r, logic ev, logic [13:0] ec,
                                logic [31:0] ep, logic [31:0] ei, logic [4:0] er, logic [3:0] en);
        vec_t t;
        t.stall = st; t.flush = fl; t.valid = v; t.ctrl = c; t.pc = p; t.imm = i; t.rd = r;
        t.exp_valid = ev; t.exp_ctrl = ec; t.exp_pc = ep; t.exp_imm = ei; t.exp_rd = er;
        t.exp_cnt = en;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(logic st, logic fl, logic v, logic [13:0] c, logic [31:0] p,
                         logic [31:0] i, logic [4:0] r);
        stall_e = st; flush_e = fl; valid_d = v;
        {regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d,
         result_src_d, alu_control_d, branch_control_d} = c;
        pc_d = p; imm_ext_d = i; rd_d = r;
        rd1_d = p + 32'h1111; rd2_d = p + 32'h2222; pc_plus4_d = p + 32'd4;
        rs1_d = r + 5'd1; rs2_d = r + 5'd2;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] ctrl_e();
        return {regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e,
                result_src_e, alu_control_e, branch_control_e};
    endfunction

    function automatic logic [63:0] all_out_or();
        return 64'(valid_e | (|ctrl_e()) | (|rd1_e) | (|rd2_e) | (|pc_e) | (|pc_plus4_e)
               | (|imm_ext_e) | (|rs1_e) | (|rs2_e) | (|rd_e) | (|bubble_cnt));
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 1, C_LOAD,   32'h100, 32'h10, 5'd7, 1, C_LOAD,   32'h100, 32'h10, 5'd7, 4'd0);
        vecs[1]  = mk(1, 0, 1, C_STORE,  32'h104, 32'h08, 5'd0, 1, C_LOAD,   32'h100, 32'h10, 5'd7, 4'd0);
        vecs[2]  = mk(1, 0, 1, C_STORE,  32'h104, 32'h08, 5'd0, 1, C_LOAD,   32'h100, 32'h10, 5'd7, 4'd0);
        vecs[3]  = mk(1, 0, 1, C_STORE,  32'h104, 32'h08, 5'd0, 1, C_LOAD,   32'h100, 32'h10, 5'd7, 4'd0);
        vecs[4]  = mk(0, 0, 1, C_STORE,  32'h104, 32'h08, 5'd0, 1, C_STORE,  32'h104, 32'h08, 5'd0, 4'd0);
        vecs[5]  = mk(0, 0, 1, C_BRANCH, 32'h200, 32'h20, 5'd0, 1, C_BRANCH, 32'h200, 32'h20, 5'd0, 4'd0);
        vecs[6]  = mk(0, 1, 1, C_BRANCH, 32'h200, 32'h20, 5'd0, 0, 14'h0,    32'h0,   32'h0,  5'd0, 4'd1);
        vecs[7]  = mk(0, 0, 1, C_JAL,    32'h300, 32'h40, 5'd1, 1, C_JAL,    32'h300, 32'h40, 5'd1, 4'd1);
        vecs[8]  = mk(1, 1, 1, C_JAL,    32'h300, 32'h40, 5'd1, 0, 14'h0,    32'h0,   32'h0,  5'd0, 4'd2);
        vecs[9]  = mk(0, 0, 0, C_RWMW,   32'h400, 32'h50, 5'd9, 0, 14'h0,    32'h400, 32'h50, 5'd9, 4'd3);
        vecs[10] = mk(1, 0, 0, C_JAL,    32'h500, 32'h60, 5'd3, 0, 14'h0,    32'h400, 32'h50, 5'd9, 4'd3);
        vecs[11] = mk(0, 0, 1, C_JAL,    32'h500, 32'h60, 5'd3, 1, C_JAL,    32'h500, 32'h60, 5'd3, 4'd3);

        reset = 1'b1;
        drive(0, 0, 0, 14'h0, 32'h0, 32'h0, 5'd0);
        step();
        step();
        check("reset_all_zero", all_out_or(), 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].stall, vecs[k].flush, vecs[k].valid, vecs[k].ctrl,
                  vecs[k].pc, vecs[k].imm, vecs[k].rd);
            step();
            check($sformatf("v%0d_valid", k), 64'(valid_e),    64'(vecs[k].exp_valid));
            check($sformatf("v%0d_ctrl", k),  64'(ctrl_e()),   64'(vecs[k].exp_ctrl));
            check($sformatf("v%0d_pc", k),    64'(pc_e),       64'(vecs[k].exp_pc));
            check($sformatf("v%0d_imm", k),   64'(imm_ext_e),  64'(vecs[k].exp_imm));
            check($sformatf("v%0d_rd", k),    64'(rd_e),       64'(vecs[k].exp_rd));
            check($sformatf("v%0d_cnt", k),   64'(bubble_cnt), 64'(vecs[k].exp_cnt));
            if (k == 0) begin
                check("load_rd1",  64'(rd1_e),      64'h1211);
                check("load_rd2",  64'(rd2_e),      64'h2322);
                check("load_pc4",  64'(pc_plus4_e), 64'h104);
                check("load_rs1",  64'(rs1_e),      64'd8);
                check("load_rs2",  64'(rs2_e),      64'd9);
            end
        end

        // Saturation: counter sits at 3 and must stop at 15 without wrapping.
        for (int n = 1; n <= 20; n++) begin
            drive(0, 1, 1, C_JAL, 32'h600, 32'h70, 5'd4);
            step();
            check($sformatf("sat_cnt_%0d", n), 64'(bubble_cnt), 64'((3 + n > 15) ? 15 : 3 + n));
        end
        check("sat_flush_valid", 64'(valid_e), 64'd0);

        // Reset asserted during a stall with a live instruction in execute.
        drive(0, 0, 1, C_JAL, 32'h700, 32'h80, 5'd5);
        step();
        check("pre_reset_valid", 64'(valid_e), 64'd1);
        check("pre_reset_pc4",   64'(pc_plus4_e), 64'h704);
        reset = 1'b1;
        stall_e = 1'b1;
        step();
        check("reset_mid_all_zero", all_out_or(), 64'd0);
        check("reset_mid_cnt", 64'(bubble_cnt), 64'd0);
        reset = 1'b0;
        stall_e = 1'b0;

        // First capture after reset counts an empty slot exactly once.
        drive(0, 0, 0, C_STORE, 32'h800, 32'h90, 5'd6);
        step();
        check("post_reset_cnt", 64'(bubble_cnt), 64'd1);
        check("post_reset_rd",  64'(rd_e),       64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register for the 5-stage pipelined RISC-V core.
- Captures the decode-stage control bundle (regwrite, memwrite, jump, branch, alu_src, result_src, alu_control, branch_control) and the decode datapath fields, and presents them to the execute stage one cycle later.
- Supports stall (hold), flush (bubble insertion) and valid propagation.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width (register data, PC, immediate)
- REG_ADDR_W, 5, register index width
- CNT_W, 16, width of the bubble counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall_e  input  1  hold current execute-stage contents
- flush_e  input  1  replace next execute-stage contents with a bubble
- valid_d  input  1  decode stage holds a real instruction
- regwrite_d  input  1  register-file write enable
- memwrite_d  input  1  data-memory write enable
- jump_d  input  1  jal instruction
- branch_d  input  1  conditional branch
- alu_src_d  input  1  ALU B operand select (1 = immediate)
- result_src_d  input  2  writeback result select
- alu_control_d  input  4  ALU operation
- branch_control_d  input  3  branch condition (funct3)
- rd1_d, rd2_d  input  XLEN  register-file read data
- pc_d, pc_plus4_d  input  XLEN  instruction PC and PC+4
- imm_ext_d  input  XLEN  sign-extended immediate
- rs1_d, rs2_d, rd_d  input  REG_ADDR_W  source and destination register indices
- valid_e  output  1  execute stage holds a real instruction
- regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e  output  1 each  registered copies
- result_src_e  output  2  registered copy
- alu_control_e  output  4  registered copy
- branch_control_e  output  3  registered copy
- rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e  output  XLEN  registered copies
- rs1_e, rs2_e, rd_e  output  REG_ADDR_W  registered copies
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset

Behaviour:
- All outputs are registered; there is no combinational path from input to output.
- Each rising clk is evaluated in the following priority order.
  1. reset=1: every output, including bubble_cnt and valid_e, is set to 0.
  2. flush_e=1: a bubble is loaded. Every _e output and valid_e become 0. Flush wins over stall_e.
  3. stall_e=1: every _e output and valid_e hold their previous values.
  4. Otherwise: all _d inputs are captured into the matching _e outputs, and valid_e <= valid_d.
- Capture with valid_d=0: the five 1-bit control outputs (regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e), result_src_e, alu_control_e, branch_control_e and valid_e are forced to 0. Data fields are still captured. This keeps invalid slots architecturally inert.
- Latency: exactly 1 cycle from _d inputs to _e outputs when not stalled or flushed.
- bubble_cnt:
  - Increments by 1 on any non-reset edge where flush_e=1.
  - Also increments on a non-reset, non-stall capture edge with valid_d=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Does not change on stall cycles.
- Simultaneous stall_e=1 and flush_e=1: treated as a flush, and the counter increments.
- reset asserted during a stall or flush: reset has priority and all outputs go to 0 on that edge.
- No X is allowed on any output after the first reset edge.

Test Plan:
- Basic capture: reset for 2 cycles, then drive a load word with valid_d=1, regwrite_d=1, alu_src_d=1, result_src_d=2'b01, alu_control_d=4'b0000, rd_d=5'd7, imm_ext_d=32'h10, pc_d=32'h100. Next cycle the _e outputs must carry exactly these values, valid_e=1 and bubble_cnt=0.
- Stall hold: with the load captured, hold stall_e=1 for 3 cycles while the _d inputs change to a store (memwrite_d=1, rd_d=5'd0). The _e outputs must stay at the load values. One cycle after stall_e deasserts, the store values must appear.
- Flush bubble: capture a branch (branch_d=1, branch_control_d=3'b001, pc_d=32'h200), then assert flush_e=1 for one cycle. All _e outputs and valid_e must be 0, and bubble_cnt must be 1.
- Flush over stall: assert stall_e=1 and flush_e=1 together while a jal is held (jump_e=1, regwrite_e=1). Next cycle jump_e=0, regwrite_e=0, valid_e=0 and bubble_cnt increments by 1.
- Invalid capture plus saturation:
  - Drive valid_d=0 with regwrite_d=1, memwrite_d=1. After the edge, regwrite_e=0, memwrite_e=0, valid_e=0 and rd_e equals rd_d.
  - With CNT_W=4, flush 20 times; bubble_cnt must stop at 15.
- Reset mid-operation: assert reset in the same cycle as stall_e=1 while valid_e=1. Next cycle every output, including bubble_cnt, must be 0.
